// File: rtl/dcache_wb_pkg.sv
// dcache_wb_pkg: shared encodings for the write-back data cache.
// Access length codes, FSM state codes and boolean helpers.
package dcache_wb_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_RESP,
    S_FL_SCAN,
    S_FL_WB,
    S_FL_DONE
  } state_e;

  // Bytes touched by an access; code 3 behaves as a word.
  function automatic int len_nbytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 1;
      LEN_HALF: return 2;
      LEN_WORD: return 4;
      default:  return 4;
    endcase
  endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// dcache_wb_if: core-side and memory-side bundles of the data cache.
// Core side: load/store/flush request + result; memory side: byte engine.
interface dcache_core_if #(
  parameter int ADDR_W = 17
);
  logic              read_i;
  logic              write_i;
  logic              sign_i;
  logic [1:0]        len_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       w_data_i;
  logic [31:0]       r_data_o;
  logic              done_o;
  logic              flush_i;
  logic              flush_done_o;

  modport master (
    output read_i, write_i, sign_i, len_i,
    output addr_i, w_data_i, flush_i,
    input  r_data_o, done_o, flush_done_o
  );

  modport slave (
    input  read_i, write_i, sign_i, len_i,
    input  addr_i, w_data_i, flush_i,
    output r_data_o, done_o, flush_done_o
  );
endinterface

interface dcache_mem_if #(
  parameter int ADDR_W = 17
);
  logic              read_o;
  logic              write_o;
  logic [ADDR_W-1:0] addr_o;
  logic [7:0]        r_data_i;
  logic [7:0]        w_data_o;
  logic              done_i;

  modport master (
    output read_o, write_o, addr_o, w_data_o,
    input  r_data_i, done_i
  );

  modport slave (
    input  read_o, write_o, addr_o, w_data_o,
    output r_data_i, done_i
  );
endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data arrays of the direct-mapped cache.
// One index selects both the async read port and the byte/meta write ports.
module dcache_line_store #(
  parameter int LINES       = 64,
  parameter int BLOCK_BYTES = 8,
  parameter int TAG_W       = 8,
  localparam int IDX_W  = $clog2(LINES),
  localparam int LINE_W = BLOCK_BYTES * 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       idx,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [LINE_W-1:0]      rd_line,
  input  logic                   wr_en,
  input  logic [BLOCK_BYTES-1:0] wr_be,
  input  logic [LINE_W-1:0]      wr_line,
  input  logic                   meta_we,
  input  logic                   meta_valid,
  input  logic                   meta_dirty,
  input  logic [TAG_W-1:0]       meta_tag
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[idx] <= meta_valid;
      dirty_q[idx] <= meta_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_we) begin
      tag_q[idx] <= meta_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < BLOCK_BYTES; k++) begin
        if (wr_be[k]) begin
          data_q[idx][k*8 +: 8] <= wr_line[k*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back write-allocate data cache with flush.
// Ports: clk, rst, core (dcache_core_if.slave), mem (dcache_mem_if.master).
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int LINES       = 64,
  parameter int BLOCK_BYTES = 8
) (
  input logic          clk,
  input logic          rst,
  dcache_core_if.slave core,
  dcache_mem_if.master mem
);

  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = BLOCK_BYTES * 8;

  localparam logic [OFF_W-1:0] CNT_LAST  = OFF_W'(BLOCK_BYTES - 1);
  localparam logic [IDX_W-1:0] SCAN_LAST = IDX_W'(LINES - 1);

  state_e state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] scan_q, scan_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [OFF_W-1:0] al_off;
  logic [IDX_W-1:0] idx;
  int               n_bytes;

  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit;

  logic                   wr_en;
  logic [BLOCK_BYTES-1:0] wr_be;
  logic [LINE_W-1:0]      wr_line;
  logic                   meta_we;
  logic                   meta_valid;
  logic                   meta_dirty;
  logic [TAG_W-1:0]       meta_tag;

  logic [BLOCK_BYTES-1:0] mrg_be;
  logic [LINE_W-1:0]      mrg_line;
  logic [OFF_W-1:0]       rel [BLOCK_BYTES];

  logic [7:0]  by0, by1, by2, by3;
  logic [7:0]  line_byte;
  logic [31:0] ld_data;

  logic              done;
  logic              fl_done;
  logic              m_rd;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata;

  assign req_tag = core.addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx = core.addr_i[OFF_W +: IDX_W];
  assign req_off = core.addr_i[OFF_W-1:0];
  assign n_bytes = len_nbytes(core.len_i);

  // Flush walks the array by its own counter.
  assign idx = (state_q == S_FL_SCAN || state_q == S_FL_WB)
             ? scan_q : req_idx;

  always_comb begin
    unique case (core.len_i)
      LEN_BYTE: al_off = req_off;
      LEN_HALF: al_off = {req_off[OFF_W-1:1], 1'b0};
      default:  al_off = {req_off[OFF_W-1:2], 2'b00};
    endcase
  end

  dcache_line_store #(
    .LINES       (LINES),
    .BLOCK_BYTES (BLOCK_BYTES),
    .TAG_W       (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .wr_en      (wr_en),
    .wr_be      (wr_be),
    .wr_line    (wr_line),
    .meta_we    (meta_we),
    .meta_valid (meta_valid),
    .meta_dirty (meta_dirty),
    .meta_tag   (meta_tag)
  );

  assign hit = rd_valid && (rd_tag == req_tag);

  assign by0 = rd_line[{al_off, 3'b000} +: 8];
  assign by1 = rd_line[{al_off + OFF_W'(1), 3'b000} +: 8];
  assign by2 = rd_line[{al_off + OFF_W'(2), 3'b000} +: 8];
  assign by3 = rd_line[{al_off + OFF_W'(3), 3'b000} +: 8];
  assign line_byte = rd_line[{cnt_q, 3'b000} +: 8];

  always_comb begin
    unique case (core.len_i)
      LEN_BYTE: ld_data = {{24{core.sign_i & by0[7]}}, by0};
      LEN_HALF: ld_data = {{16{core.sign_i & by1[7]}}, by1, by0};
      default:  ld_data = {by3, by2, by1, by0};
    endcase
  end

  // Line byte k takes store byte (k - al_off) when that falls in the
  // access; below al_off the subtraction wraps past the access length.
  always_comb begin
    mrg_be   = '0;
    mrg_line = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      rel[k] = OFF_W'(k) - al_off;
      if (int'(rel[k]) < n_bytes) begin
        mrg_be[k] = 1'b1;
        mrg_line[k*8 +: 8] =
          core.w_data_i[{rel[k][1:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      scan_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scan_d     = scan_q;
    rdata_d    = rdata_q;
    wr_en      = FALSE;
    wr_be      = mrg_be;
    wr_line    = mrg_line;
    meta_we    = FALSE;
    meta_valid = rd_valid;
    meta_dirty = rd_dirty;
    meta_tag   = rd_tag;
    done       = FALSE;
    fl_done    = FALSE;
    m_rd       = FALSE;
    m_wr       = FALSE;
    m_addr     = '0;
    m_wdata    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (core.flush_i) begin
          state_d = S_FL_SCAN;
          scan_d  = '0;
        end else if (core.write_i || core.read_i) begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cnt_d = '0;
        if (hit) begin
          state_d = S_RESP;
          if (core.write_i) begin
            wr_en      = TRUE;
            meta_we    = TRUE;
            meta_dirty = TRUE;
          end else begin
            rdata_d = ld_data;
          end
        end else if (rd_valid && rd_dirty) begin
          state_d = S_WB;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WB: begin
        m_wr    = TRUE;
        m_addr  = {rd_tag, req_idx, cnt_q};
        m_wdata = line_byte;
        if (mem.done_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            meta_we    = TRUE;
            meta_dirty = FALSE;
            state_d    = S_FILL;
          end
        end
      end
      S_FILL: begin
        m_rd   = TRUE;
        m_addr = {req_tag, req_idx, cnt_q};
        if (mem.done_i) begin
          wr_en   = TRUE;
          wr_be   = BLOCK_BYTES'(1) << cnt_q;
          wr_line = {BLOCK_BYTES{mem.r_data_i}};
          cnt_d   = cnt_q + 1'b1;
          // Back to LOOKUP: it now hits, so a store merges there.
          if (cnt_q == CNT_LAST) begin
            meta_we    = TRUE;
            meta_valid = TRUE;
            meta_dirty = FALSE;
            meta_tag   = req_tag;
            state_d    = S_LOOKUP;
          end
        end
      end
      S_RESP: begin
        done    = TRUE;
        state_d = S_IDLE;
      end
      S_FL_SCAN: begin
        if (rd_valid && rd_dirty) begin
          state_d = S_FL_WB;
          cnt_d   = '0;
        end else begin
          meta_we    = TRUE;
          meta_valid = FALSE;
          meta_dirty = FALSE;
          scan_d     = scan_q + 1'b1;
          if (scan_q == SCAN_LAST) begin
            state_d = S_FL_DONE;
          end
        end
      end
      S_FL_WB: begin
        m_wr    = TRUE;
        m_addr  = {rd_tag, scan_q, cnt_q};
        m_wdata = line_byte;
        if (mem.done_i) begin
          cnt_d = cnt_q + 1'b1;
          // Line is now clean; the rescan invalidates and advances.
          if (cnt_q == CNT_LAST) begin
            meta_we    = TRUE;
            meta_dirty = FALSE;
            state_d    = S_FL_SCAN;
          end
        end
      end
      S_FL_DONE: begin
        fl_done = TRUE;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign core.r_data_o     = rdata_q;
  assign core.done_o       = done;
  assign core.flush_done_o = fl_done;
  assign mem.read_o        = m_rd;
  assign mem.write_o       = m_wr;
  assign mem.addr_o        = m_addr;
  assign mem.w_data_o      = m_wdata;

endmodule
